// File: rtl/intdiv_recon.sv
// intdiv_recon: iterative radix-2 Booth multiply-accumulate rebuilding x = z*y + r.
// Optional INTDIV_RECON_CHECK_EN compares x against a supplied expected dividend.
module intdiv_recon #(
    parameter int N  = 6,
    parameter int CW = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    z,
    input  logic [N-1:0]    y,
    input  logic [N-1:0]    r,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*N-1:0]  x,
    output logic            ovf
`ifdef INTDIV_RECON_CHECK_EN
    ,
    input  logic [N-1:0]    x_exp,
    output logic            mismatch,
    output logic            err_sticky
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; a source keeps valid and its data stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;
    logic               w_out_hs;

    logic [2*N-1:0]     r_acc;
    logic [2*N-1:0]     r_mcand;
    logic [N:0]         r_mplier;
    logic [CW-1:0]      r_cnt;
    logic [2*N-1:0]     r_x;
    logic               r_ovf;

    logic [2*N-1:0]     w_acc_step;
    logic [N:0]         w_top;
    logic               w_ovf_final;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_out_hs    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == CW'(N - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_out_hs    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Booth recoding of the multiplier pair {q(i), q(i-1)}.
    always_comb begin
        case (r_mplier[1:0])
            2'b01:   w_acc_step = r_acc + r_mcand;
            2'b10:   w_acc_step = r_acc - r_mcand;
            default: w_acc_step = r_acc;
        endcase
    end

    // x fits N signed bits only when its top N+1 bits are all copies of the sign.
    assign w_top       = w_acc_step[2*N-1:N-1];
    assign w_ovf_final = !((&w_top) || !(|w_top));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_x      <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_acc    <= {{N{r[N-1]}}, r};
            r_mcand  <= {{N{y[N-1]}}, y};
            r_mplier <= {z, 1'b0};
            r_cnt    <= '0;
        end else if (r_state == S_BUSY) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= {r_mplier[N], r_mplier[N:1]};
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_x   <= w_acc_step;
                r_ovf <= w_ovf_final;
            end
        end
    end

    assign x   = r_x;
    assign ovf = r_ovf;

`ifdef INTDIV_RECON_CHECK_EN
    logic [N-1:0] r_x_exp;
    logic         r_mismatch;
    logic         r_err_sticky;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_x_exp      <= '0;
            r_mismatch   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x_exp <= x_exp;
            end
            if (w_last) begin
                r_mismatch <= w_ovf_final || (w_acc_step[N-1:0] != r_x_exp);
            end
            if (w_out_hs && r_mismatch) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign mismatch   = r_mismatch;
    assign err_sticky = r_err_sticky;
`endif

endmodule
